menu_nav_ctrl: RTL and testbench
================================

Name: menu_nav_ctrl

Overview:
- Parametrised menu navigation controller between the USB keycode path and the sprite/colour mapper.
- Turns raw keycode levels into debounced, frame-paced cursor moves over NUM_ITEMS entries.
- Runs a title → navigate → confirm → launch state machine and drives the cursor index, blink and start_game outputs that the menu sprite renderer and game top level consume.

Parameters:
- NUM_ITEMS, 4, number of selectable entries; legal range 2..16.
- WRAP, 1, 1 = cursor wraps at the ends; 0 = cursor saturates at 0 / NUM_ITEMS-1.
- CONFIRM_FRAMES, 32, frame ticks spent in CONFIRM before launch; legal range 1..255.
- BLINK_FRAMES, 8, frame ticks per blink half-period during CONFIRM; legal range 1..255.
- KEY_UP, 8'h52, keycode for cursor up.
- KEY_DOWN, 8'h51, keycode for cursor down.
- KEY_ENTER, 8'h58, keycode for select.
- KEY_BACK, 8'h29, keycode for cancel (Esc).
- Derived, not overridable: IDX_W = max(1, $clog2(NUM_ITEMS)).

Ports:
- Clk, in, 1, 50 MHz system clock.
- Reset, in, 1, synchronous, active-high reset.
- frame_clk, in, 1, vertical-sync-derived frame clock (~60 Hz), asynchronous to Clk.
- keycode, in, 8, currently pressed key; 8'h00 = none.
- cursor, out, IDX_W, highlighted entry index.
- menu_state, out, 2, 0 = TITLE, 1 = NAV, 2 = CONFIRM, 3 = LAUNCH.
- blink, out, 1, highlight visibility for the renderer.
- selected, out, IDX_W, entry latched on Enter.
- start_game, out, 1, level; high only in LAUNCH.

Behaviour:
- Reset (synchronous, active-high) is the only reset and is sampled only on posedge Clk.
- Reset values: cursor = 0, menu_state = TITLE, blink = 1, selected = 0, start_game = 0; all internal counters = 0, prev_key = 8'h00.
- Reset asserted in any state, including mid-CONFIRM, returns to TITLE on the next Clk edge. Reset wins over a coincident tick.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser, then a rising-edge detector.
  - tick is a 1-Clk pulse, 3 Clk cycles after the frame_clk rise.
  - All state, cursor and counter updates occur only on Clk edges where tick = 1.
- Key edge:
  - On each tick, press = (keycode != 8'h00) && (keycode != prev_key); then prev_key <= keycode.
  - A held key produces exactly one press, unless the optional feature below is enabled.
  - Keycode changes between ticks are not seen.
- TITLE: any press → NAV, cursor = 0.
- NAV:
  - press KEY_UP: cursor - 1. At 0, goes to NUM_ITEMS-1 if WRAP = 1, else holds at 0.
  - press KEY_DOWN: cursor + 1. At NUM_ITEMS-1, goes to 0 if WRAP = 1, else holds.
  - Arithmetic is done in IDX_W bits with an explicit compare against NUM_ITEMS-1; never rely on natural overflow, since NUM_ITEMS need not be a power of 2.
  - press KEY_ENTER: selected <= cursor, → CONFIRM, confirm counter = 0, blink = 1.
  - KEY_BACK and all other keys in NAV: no effect.
- CONFIRM:
  - Each tick increments the confirm counter.
  - blink toggles each time the blink counter reaches BLINK_FRAMES-1; the blink counter then returns to 0.
  - press KEY_BACK → NAV with blink = 1; cursor is unchanged and selected retains its value.
  - When the confirm counter reaches CONFIRM_FRAMES-1 on a tick → LAUNCH.
  - If KEY_BACK is pressed on that same final tick, KEY_BACK wins and the next state is NAV.
  - Up/Down/Enter are ignored in CONFIRM.
- LAUNCH:
  - start_game = 1, blink = 1.
  - All keys are ignored; the state is held until Reset.
- Outputs are registered with no combinational path from keycode.
- cursor never exceeds NUM_ITEMS-1.

Optional Feature:
- Macro: MENU_AUTOREPEAT_EN.
- Defined:
  - In NAV, if KEY_UP or KEY_DOWN is held unchanged for 20 ticks, a repeat move fires.
  - Further repeat moves fire every 6 ticks while the key stays held.
  - Releasing or changing the key clears the hold counter.
  - Repeat moves obey the same WRAP rules as presses.
  - Enter and Back never repeat.
- Undefined: no hold counter exists; only edge presses move the cursor.

Test Plan:
- Reset, then press 8'h28 on one tick → menu_state = 1, cursor = 0, start_game = 0.
- NUM_ITEMS = 4, WRAP = 1: in NAV, KEY_UP pressed and released 1×, 5 ticks apart → cursor = 3. Then KEY_DOWN pressed and released 2× → cursor = 1.
- WRAP = 0, NUM_ITEMS = 3: KEY_DOWN pressed and released 5× → cursor saturates at 2. KEY_DOWN held for 100 ticks without the macro → exactly one move.
- Cursor = 2, KEY_ENTER → selected = 2, state = 2. blink toggles every 8 ticks. After CONFIRM_FRAMES = 32 ticks → state = 3, start_game = 1. KEY_UP afterwards leaves cursor = 2.
- In CONFIRM at tick 10, KEY_BACK → state = 1, blink = 1, cursor = 2. Second case: KEY_BACK on the final confirm tick → state = 1, not 3.
- Reset asserted mid-CONFIRM, coincident with a tick → next Clk: state = 0, cursor = 0, start_game = 0. With MENU_AUTOREPEAT_EN: KEY_DOWN held for 32 ticks → 1 + 1 + 2 = 4 moves total (initial press, first repeat at 20 ticks, repeats at 26 and 32).

Source files
------------

// File: rtl/menu_nav_ctrl.sv
// menu_nav_ctrl
//   Menu navigation controller sitting between the USB keycode path and the
//   menu sprite/colour mapper. Raw keycode levels are sampled once per frame
//   tick, edge-detected into presses, and used to move a cursor over
//   NUM_ITEMS entries, confirm a selection and finally launch the game.
//
// Ports
//   Clk        in   system clock (50 MHz)
//   Reset      in   synchronous, active-high reset
//   frame_clk  in   vsync-derived frame clock, asynchronous to Clk
//   keycode    in   currently pressed key, 8'h00 = none
//   cursor     out  highlighted entry index (never above NUM_ITEMS-1)
//   menu_state out  0 = TITLE, 1 = NAV, 2 = CONFIRM, 3 = LAUNCH
//   blink      out  highlight visibility for the renderer
//   selected   out  entry latched on Enter
//   start_game out  high only while in LAUNCH
//
// Build option
//   MENU_AUTOREPEAT_EN : when defined, Up/Down held unchanged in NAV repeat
//                        after 20 ticks and then every 6 ticks. When
//                        undefined, only edge presses move the cursor.
//
// States
//   TITLE   | title screen, waiting for any key press
//   NAV     | cursor moves with Up/Down, Enter selects
//   CONFIRM | selection blinking, Back cancels, launches after CONFIRM_FRAMES
//   LAUNCH  | start_game asserted, held until Reset

module menu_nav_ctrl #(
    parameter int          NUM_ITEMS      = 4,
    parameter int          WRAP           = 1,
    parameter int          CONFIRM_FRAMES = 32,
    parameter int          BLINK_FRAMES   = 8,
    parameter logic [7:0]  KEY_UP         = 8'h52,
    parameter logic [7:0]  KEY_DOWN       = 8'h51,
    parameter logic [7:0]  KEY_ENTER      = 8'h58,
    parameter logic [7:0]  KEY_BACK       = 8'h29,
    localparam int         IDX_W          = ($clog2(NUM_ITEMS) > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [7:0]       keycode,
    output logic [IDX_W-1:0] cursor,
    output logic [1:0]       menu_state,
    output logic             blink,
    output logic [IDX_W-1:0] selected,
    output logic             start_game
);

    typedef enum logic [1:0] {
        ST_TITLE   = 2'd0,
        ST_NAV     = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LAUNCH  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ITEMS - 1);
    localparam logic [7:0]       CONF_LAST  = 8'(CONFIRM_FRAMES - 1);
    localparam logic [7:0]       BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // frame_clk synchroniser and rising-edge detector
    logic sync1_q, sync2_q, sync3_q;
    logic tick;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cursor_q, cursor_d;
    logic [IDX_W-1:0] selected_q, selected_d;
    logic             blink_q, blink_d;
    logic             start_game_q;
    logic [7:0]       confirm_cnt_q, confirm_cnt_d;
    logic [7:0]       blink_cnt_q, blink_cnt_d;
    logic [7:0]       prev_key_q, prev_key_d;

    logic press;
    logic move_up;
    logic move_down;

`ifdef MENU_AUTOREPEAT_EN
    localparam logic [4:0] RPT_FIRST = 5'd20;
    localparam logic [4:0] RPT_NEXT  = 5'd26;

    // hold_cnt counts ticks the current Up/Down key has been held, with the
    // press tick counted as 1; after the first repeat it cycles 20..25.
    logic [4:0] hold_cnt_q, hold_cnt_d;
    logic [4:0] hold_next;
    logic       rpt;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // High for one Clk cycle; the state update lands on the third Clk edge
    // after frame_clk rises.
    assign tick  = sync2_q & ~sync3_q;

    assign press = (keycode != 8'h00) && (keycode != prev_key_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_TITLE;
            cursor_q      <= '0;
            selected_q    <= '0;
            blink_q       <= 1'b1;
            start_game_q  <= 1'b0;
            confirm_cnt_q <= 8'd0;
            blink_cnt_q   <= 8'd0;
            prev_key_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            selected_q    <= selected_d;
            blink_q       <= blink_d;
            start_game_q  <= (state_d == ST_LAUNCH);
            confirm_cnt_q <= confirm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            prev_key_q    <= prev_key_d;
        end
    end

`ifdef MENU_AUTOREPEAT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_cnt_q <= 5'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        selected_d    = selected_q;
        blink_d       = blink_q;
        confirm_cnt_d = confirm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        prev_key_d    = prev_key_q;
        move_up       = 1'b0;
        move_down     = 1'b0;
`ifdef MENU_AUTOREPEAT_EN
        hold_cnt_d    = hold_cnt_q;
        hold_next     = hold_cnt_q + 5'd1;
        rpt           = 1'b0;
`endif

        if (tick) begin
            prev_key_d = keycode;

`ifdef MENU_AUTOREPEAT_EN
            // Anything other than Up/Down held in NAV clears the hold count.
            hold_cnt_d = 5'd0;
            if ((state_q == ST_NAV) && ((keycode == KEY_UP) || (keycode == KEY_DOWN))) begin
                if (press) begin
                    hold_cnt_d = 5'd1;
                end else if (hold_next == RPT_FIRST) begin
                    rpt        = 1'b1;
                    hold_cnt_d = hold_next;
                end else if (hold_next == RPT_NEXT) begin
                    rpt        = 1'b1;
                    hold_cnt_d = RPT_FIRST;
                end else begin
                    hold_cnt_d = hold_next;
                end
            end
`endif

            case (state_q)
                ST_TITLE: begin
                    if (press) begin
                        state_d  = ST_NAV;
                        cursor_d = '0;
                    end
                end

                ST_NAV: begin
                    move_up   = press && (keycode == KEY_UP);
                    move_down = press && (keycode == KEY_DOWN);
`ifdef MENU_AUTOREPEAT_EN
                    if (rpt) begin
                        move_up   = (keycode == KEY_UP);
                        move_down = (keycode == KEY_DOWN);
                    end
`endif
                    if (press && (keycode == KEY_ENTER)) begin
                        selected_d    = cursor_q;
                        state_d       = ST_CONFIRM;
                        confirm_cnt_d = 8'd0;
                        blink_cnt_d   = 8'd0;
                        blink_d       = 1'b1;
                    end
                end

                ST_CONFIRM: begin
                    if (press && (keycode == KEY_BACK)) begin
                        // Back wins even on the final confirm tick.
                        state_d       = ST_NAV;
                        blink_d       = 1'b1;
                        confirm_cnt_d = 8'd0;
                        blink_cnt_d   = 8'd0;
                    end else if (confirm_cnt_q == CONF_LAST) begin
                        state_d       = ST_LAUNCH;
                        blink_d       = 1'b1;
                        confirm_cnt_d = confirm_cnt_q + 8'd1;
                    end else begin
                        confirm_cnt_d = confirm_cnt_q + 8'd1;
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_d     = ~blink_q;
                            blink_cnt_d = 8'd0;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 8'd1;
                        end
                    end
                end

                ST_LAUNCH: begin
                    blink_d = 1'b1;
                end

                default: begin
                    state_d = ST_TITLE;
                end
            endcase

            // Explicit end-of-range compares: NUM_ITEMS need not be a power of 2.
            if (move_up) begin
                if (cursor_q == '0) begin
                    cursor_d = (WRAP != 0) ? LAST_IDX : '0;
                end else begin
                    cursor_d = cursor_q - IDX_W'(1);
                end
            end else if (move_down) begin
                if (cursor_q >= LAST_IDX) begin
                    cursor_d = (WRAP != 0) ? '0 : LAST_IDX;
                end else begin
                    cursor_d = cursor_q + IDX_W'(1);
                end
            end
        end
    end

    assign cursor     = cursor_q;
    assign menu_state = state_q;
    assign blink      = blink_q;
    assign selected   = selected_q;
    assign start_game = start_game_q;

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Directed bench for menu_nav_ctrl. Two instances share clock, reset and
// frame_clk: dut_a (4 items, wrapping, default timing) and dut_b (3 items,
// saturating). Each has its own keycode.

module tb_menu_nav_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] key_a = 8'h00;
    logic [7:0] key_b = 8'h00;

    logic [1:0] cur_a, sel_a, st_a;
    logic       blk_a, sg_a;
    logic [1:0] cur_b, sel_b, st_b;
    logic       blk_b, sg_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 Clk = ~Clk;

    menu_nav_ctrl #(.NUM_ITEMS(4), .WRAP(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(key_a),
        .cursor(cur_a), .menu_state(st_a), .blink(blk_a),
        .selected(sel_a), .start_game(sg_a)
    );

    menu_nav_ctrl #(.NUM_ITEMS(3), .WRAP(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(key_b),
        .cursor(cur_b), .menu_state(st_b), .blink(blk_b),
        .selected(sel_b), .start_game(sg_b)
    );

    typedef struct {
        logic [7:0] key;
        logic [1:0] st;
        logic [1:0] cur;
        logic       blk;
        logic [1:0] sel;
        logic       sg;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame tick with the given keys; outputs are stable on return.
    task automatic tick(input logic [7:0] ka, input logic [7:0] kb);
        @(negedge Clk);
        key_a     = ka;
        key_b     = kb;
        frame_clk = 1'b1;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = 1'b0;
        key_a     = 8'h00;
        key_b     = 8'h00;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic chk_a(input string name, input int st, input int cur,
                         input int blk, input int sel, input int sg);
        chk({name, ".state"},    int'(st_a),  st);
        chk({name, ".cursor"},   int'(cur_a), cur);
        chk({name, ".blink"},    int'(blk_a), blk);
        chk({name, ".selected"}, int'(sel_a), sel);
        chk({name, ".start"},    int'(sg_a),  sg);
    endtask

    initial begin
        // key, state, cursor, blink, selected, start_game (dut_a, from TITLE)
        vecs[0]  = '{8'h28, 2'd1, 2'd0, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{8'h00, 2'd1, 2'd0, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{8'h52, 2'd1, 2'd3, 1'b1, 2'd0, 1'b0};
        vecs[3]  = '{8'h00, 2'd1, 2'd3, 1'b1, 2'd0, 1'b0};
        vecs[4]  = '{8'h00, 2'd1, 2'd3, 1'b1, 2'd0, 1'b0};
        vecs[5]  = '{8'h00, 2'd1, 2'd3, 1'b1, 2'd0, 1'b0};
        vecs[6]  = '{8'h00, 2'd1, 2'd3, 1'b1, 2'd0, 1'b0};
        vecs[7]  = '{8'h51, 2'd1, 2'd0, 1'b1, 2'd0, 1'b0};
        vecs[8]  = '{8'h00, 2'd1, 2'd0, 1'b1, 2'd0, 1'b0};
        vecs[9]  = '{8'h51, 2'd1, 2'd1, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{8'h29, 2'd1, 2'd1, 1'b1, 2'd0, 1'b0};
        vecs[11] = '{8'h51, 2'd1, 2'd2, 1'b1, 2'd0, 1'b0};
        vecs[12] = '{8'h51, 2'd1, 2'd2, 1'b1, 2'd0, 1'b0};
        vecs[13] = '{8'h04, 2'd1, 2'd2, 1'b1, 2'd0, 1'b0};
        vecs[14] = '{8'h58, 2'd2, 2'd2, 1'b1, 2'd2, 1'b0};

        do_reset();
        #1;
        chk_a("reset_a", 0, 0, 1, 0, 0);
        chk("reset_b.state",  int'(st_b),  0);
        chk("reset_b.cursor", int'(cur_b), 0);
        chk("reset_b.start",  int'(sg_b),  0);

        // dut_b: saturating cursor over 3 entries
        tick(8'h00, 8'h28);
        chk("b_title_nav.state", int'(st_b), 1);
        chk("b_title_nav.cursor", int'(cur_b), 0);
        tick(8'h00, 8'h52);
        chk("b_up_at_0", int'(cur_b), 0);
        tick(8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick(8'h00, 8'h51);
            chk($sformatf("b_down_%0d", i), int'(cur_b), (i + 1 > 2) ? 2 : i + 1);
            tick(8'h00, 8'h00);
        end
        tick(8'h00, 8'h52);
        chk("b_up_from_2", int'(cur_b), 1);
        tick(8'h00, 8'h00);
        tick(8'h00, 8'h52);
        chk("b_up_to_0", int'(cur_b), 0);
        tick(8'h00, 8'h00);
        for (int t = 1; t <= 100; t++) begin
            tick(8'h00, 8'h51);
            if (t == 1 || t == 19)
                chk($sformatf("b_hold_t%0d", t), int'(cur_b), 1);
        end
`ifdef MENU_AUTOREPEAT_EN
        chk("b_hold_end", int'(cur_b), 2);
`else
        chk("b_hold_end", int'(cur_b), 1);
`endif
        tick(8'h00, 8'h00);

        // dut_a: table of single-tick vectors through NAV into CONFIRM
        for (int i = 0; i < 15; i++) begin
            tick(vecs[i].key, 8'h00);
            chk_a($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].cur),
                  int'(vecs[i].blk), int'(vecs[i].sel), int'(vecs[i].sg));
        end

        // CONFIRM to LAUNCH; Down/Enter mid-confirm must be ignored
        for (int k = 1; k <= 32; k++) begin
            tick((k == 5) ? 8'h51 : ((k == 6) ? 8'h58 : 8'h00), 8'h00);
            chk($sformatf("conf_k%0d.state", k), int'(st_a), (k == 32) ? 3 : 2);
            chk($sformatf("conf_k%0d.blink", k), int'(blk_a),
                (k == 32) ? 1 : (((k / 8) % 2 == 0) ? 1 : 0));
            chk($sformatf("conf_k%0d.start", k), int'(sg_a), (k == 32) ? 1 : 0);
            chk($sformatf("conf_k%0d.cursor", k), int'(cur_a), 2);
        end
        tick(8'h52, 8'h00);
        chk_a("launch_up", 3, 2, 1, 2, 1);
        tick(8'h29, 8'h00);
        chk_a("launch_back", 3, 2, 1, 2, 1);

        // Back at tick 10 and Back on the final confirm tick
        do_reset();
        tick(8'h28, 8'h00);
        tick(8'h00, 8'h00);
        tick(8'h51, 8'h00);
        tick(8'h00, 8'h00);
        tick(8'h51, 8'h00);
        tick(8'h58, 8'h00);
        chk_a("re_enter", 2, 2, 1, 2, 0);
        for (int k = 1; k <= 9; k++) tick(8'h00, 8'h00);
        chk("k9.blink", int'(blk_a), 0);
        tick(8'h29, 8'h00);
        chk_a("back_k10", 1, 2, 1, 2, 0);
        tick(8'h00, 8'h00);
        tick(8'h58, 8'h00);
        chk("enter2.state", int'(st_a), 2);
        for (int k = 1; k <= 31; k++) tick(8'h00, 8'h00);
        chk("k31.state", int'(st_a), 2);
        tick(8'h29, 8'h00);
        chk("back_final.state", int'(st_a), 1);
        chk("back_final.start", int'(sg_a), 0);
        chk("back_final.blink", int'(blk_a), 1);

        // Reset coincident with a tick mid-CONFIRM (Back held would go to NAV)
        tick(8'h00, 8'h00);
        tick(8'h58, 8'h00);
        for (int k = 1; k <= 3; k++) tick(8'h00, 8'h00);
        chk("pre_rst.state", int'(st_a), 2);
        @(negedge Clk);
        key_a     = 8'h29;
        frame_clk = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk_a("rst_tick", 0, 0, 1, 0, 0);
        key_a = 8'h00;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk("post_rst.state", int'(st_a), 0);

`ifdef MENU_AUTOREPEAT_EN
        // Down held for 32 ticks: moves at 1, 20, 26, 32
        do_reset();
        tick(8'h28, 8'h00);
        tick(8'h00, 8'h00);
        for (int k = 1; k <= 32; k++) begin
            int moves;
            tick(8'h51, 8'h00);
            moves = 1 + ((k >= 20) ? 1 + (k - 20) / 6 : 0);
            chk($sformatf("rpt_k%0d", k), int'(cur_a), moves % 4);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
